// File: rtl/vga_dither_out.sv
// vga_dither_out: output stage behind the test-pattern controller. Reduces 8-bit RGB to
// OUT_BITS per channel with a 4x4 ordered (Bayer) dither, optionally rotated every frame,
// and delays syncs/blanks so that colour, sync and blank all leave with a 2-cycle latency.
// Pixel position is rebuilt locally from the blank flags; no h/v counts come in.
module vga_dither_out #(
    parameter int unsigned OUT_BITS   = 2,    // legal range 1..7
    parameter int unsigned TEMPORAL   = 1,
    parameter logic        SYNC_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [7:0]          r_in,
    input  logic [7:0]          g_in,
    input  logic [7:0]          b_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblank_in,
    input  logic                vblank_in,
    input  logic                visible_in,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                hblank_out,
    output logic                vblank_out,
    output logic [3:0]          frame_out
);

    // Bits dropped per channel, and how the 4-bit threshold is scaled to that step size.
    localparam int unsigned SHIFT   = 8 - OUT_BITS;
    localparam int unsigned ADD_SHL = (SHIFT >= 4) ? SHIFT - 4 : 0;
    localparam int unsigned ADD_SHR = (SHIFT < 4) ? 4 - SHIFT : 0;
    localparam logic        TEMP_ON = (TEMPORAL != 0);

    logic [9:0] x_cnt;
    logic [9:0] y_cnt;
    logic       hblank_d;
    logic       vblank_d;
    logic       hblank_rise;
    logic       vblank_rise;

    logic [1:0] xi;
    logic [1:0] yi;
    logic [3:0] thresh;
    logic [7:0] add;

    // Stage-1 registers
    logic [7:0] r_s1;
    logic [7:0] g_s1;
    logic [7:0] b_s1;
    logic [7:0] add_s1;
    logic       vis_s1;
    logic       hsync_s1;
    logic       vsync_s1;
    logic       hblank_s1;
    logic       vblank_s1;

    assign hblank_rise = hblank_in & ~hblank_d;
    assign vblank_rise = vblank_in & ~vblank_d;

    // Saturating add of the dither offset, then keep the top OUT_BITS bits.
    function automatic logic [OUT_BITS-1:0] quantize(input logic [7:0] c, input logic [7:0] a);
        logic [8:0] sum;
        logic [7:0] sat;
        sum = {1'b0, c} + {1'b0, a};
        sat = sum[8] ? 8'hFF : sum[7:0];
        return sat[7:SHIFT];
    endfunction

    // Column, line and frame tracking derived from the blank edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt     <= 10'd0;
            y_cnt     <= 10'd0;
            frame_out <= 4'd0;
            hblank_d  <= 1'b1;
            vblank_d  <= 1'b1;
        end else begin
            x_cnt <= hblank_in ? 10'd0 : x_cnt + 10'd1;
            // Line count is cleared by the last hblank edge seen inside vertical blanking.
            if (hblank_rise) begin
                y_cnt <= vblank_in ? 10'd0 : y_cnt + 10'd1;
            end
            if (vblank_rise) begin
                frame_out <= frame_out + 4'd1;
            end
            hblank_d <= hblank_in;
            vblank_d <= vblank_in;
        end
    end

    // Bayer threshold for the current pixel, scaled to one output LSB.
    always_comb begin
        xi     = x_cnt[1:0] + (frame_out[1:0] & {2{TEMP_ON}});
        yi     = y_cnt[1:0] + (frame_out[3:2] & {2{TEMP_ON}});
        thresh = 4'd0;
        unique case ({yi, xi})
            4'b00_00: thresh = 4'd0;
            4'b00_01: thresh = 4'd8;
            4'b00_10: thresh = 4'd2;
            4'b00_11: thresh = 4'd10;
            4'b01_00: thresh = 4'd12;
            4'b01_01: thresh = 4'd4;
            4'b01_10: thresh = 4'd14;
            4'b01_11: thresh = 4'd6;
            4'b10_00: thresh = 4'd3;
            4'b10_01: thresh = 4'd11;
            4'b10_10: thresh = 4'd1;
            4'b10_11: thresh = 4'd9;
            4'b11_00: thresh = 4'd15;
            4'b11_01: thresh = 4'd7;
            4'b11_10: thresh = 4'd13;
            4'b11_11: thresh = 4'd5;
        endcase
        add = en ? ((8'(thresh) << ADD_SHL) >> ADD_SHR) : 8'd0;
    end

    // Stage 1: capture colour, offset and flags for the pixel presented this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 8'd0;
            g_s1      <= 8'd0;
            b_s1      <= 8'd0;
            add_s1    <= 8'd0;
            vis_s1    <= 1'b0;
            hsync_s1  <= SYNC_RESET;
            vsync_s1  <= SYNC_RESET;
            hblank_s1 <= 1'b1;
            vblank_s1 <= 1'b1;
        end else begin
            r_s1      <= r_in;
            g_s1      <= g_in;
            b_s1      <= b_in;
            add_s1    <= add;
            vis_s1    <= visible_in;
            hsync_s1  <= hsync_in;
            vsync_s1  <= vsync_in;
            hblank_s1 <= hblank_in;
            vblank_s1 <= vblank_in;
        end
    end

    // Stage 2: quantise colour (black outside the active area) and re-time the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
            hsync_out  <= SYNC_RESET;
            vsync_out  <= SYNC_RESET;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
        end else begin
            r_out      <= vis_s1 ? quantize(r_s1, add_s1) : '0;
            g_out      <= vis_s1 ? quantize(g_s1, add_s1) : '0;
            b_out      <= vis_s1 ? quantize(b_s1, add_s1) : '0;
            hsync_out  <= hsync_s1;
            vsync_out  <= vsync_s1;
            hblank_out <= hblank_s1;
            vblank_out <= vblank_s1;
        end
    end

endmodule
